// File: rtl/ram_burst_master_if.sv
// ---------------------------------------------------------------------------
// ram_burst_master_if
//
// Bundles the command, write-data, read-data and RAM-drive signals of
// ram_burst_master. The master modport is the burst engine's view; the slave
// modport is the view of whatever drives commands/data and hosts the RAM.
//
// Signals
//   cmd_valid/cmd_ready   command handshake
//   cmd_write             1 = write burst, 0 = read burst
//   cmd_addr              burst start address
//   cmd_len               word count, 0 .. 2**Addr_width
//   wr_data/valid/ready   write-data stream into the engine
//   rd_data/valid/ready   read-data stream out of the engine
//   mem_we/address/d      single-port RAM drive
//   mem_q                 RAM read data, one cycle after its address
//   busy                  engine not idle
//   done                  one-cycle pulse at burst end
// ---------------------------------------------------------------------------
interface ram_burst_master_if #(
   parameter int Data_width = 32,
   parameter int Addr_width = 7
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [Addr_width-1:0] cmd_addr;
   logic [Addr_width:0]   cmd_len;
   logic [Data_width-1:0] wr_data;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [Data_width-1:0] rd_data;
   logic                  rd_valid;
   logic                  rd_ready;
   logic                  mem_we;
   logic [Addr_width-1:0] mem_address;
   logic [Data_width-1:0] mem_d;
   logic [Data_width-1:0] mem_q;
   logic                  busy;
   logic                  done;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len,
      input  wr_data, wr_valid, rd_ready, mem_q,
      output cmd_ready, wr_ready, rd_data, rd_valid,
      output mem_we, mem_address, mem_d, busy, done
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_len,
      output wr_data, wr_valid, rd_ready, mem_q,
      input  cmd_ready, wr_ready, rd_data, rd_valid,
      input  mem_we, mem_address, mem_d, busy, done
   );
endinterface

// File: rtl/ram_burst_master.sv
// ---------------------------------------------------------------------------
// ram_burst_master
//
// Burst engine between a command/stream interface and a single-port
// synchronous RAM. A write burst copies wr_data beats into consecutive RAM
// words; a read burst streams consecutive RAM words out on rd_data, one word
// per two cycles at most. Addresses wrap modulo 2**Addr_width.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   abort  (only with RAM_BURST_MASTER_ABORT_EN) ends the running burst early
//   bus    ram_burst_master_if.master, see the interface file
//
// Optional feature macro: RAM_BURST_MASTER_ABORT_EN
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | waiting for a command, cmd_ready high
// S_WRITE      | accepting write beats, one RAM write per beat next cycle
// S_RD_ISSUE   | presenting the next read address once rd_data is free
// S_RD_CAPTURE | capturing mem_q into rd_data
// S_DONE       | one-cycle done pulse, back to S_IDLE
// ---------------------------------------------------------------------------
module ram_burst_master #(
   parameter int Data_width = 32,
   parameter int Addr_width = 7
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef RAM_BURST_MASTER_ABORT_EN
   input  logic               abort,
`endif
   ram_burst_master_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_RD_ISSUE,
      S_RD_CAPTURE,
      S_DONE
   } state_t;

   localparam logic [Addr_width:0] LenZero = '0;
   localparam logic [Addr_width:0] LenOne  = {{Addr_width{1'b0}}, 1'b1};

   state_t                r_state;
   state_t                w_next;

   logic [Addr_width-1:0] r_addr;
   logic [Addr_width:0]   r_remain;
   logic                  r_mem_we;
   logic [Addr_width-1:0] r_mem_address;
   logic [Data_width-1:0] r_mem_d;
   logic [Data_width-1:0] r_rd_data;
   logic                  r_rd_valid;

   logic                  w_abort;
   logic                  w_cmd_ready;
   logic                  w_wr_ready;
   logic                  w_busy;
   logic                  w_done;
   logic                  w_beat;
   logic                  w_issue;
   logic                  w_capture;

`ifdef RAM_BURST_MASTER_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               if (bus.cmd_len == LenZero) begin
                  w_next = S_DONE;
               end else if (bus.cmd_write) begin
                  w_next = S_WRITE;
               end else begin
                  w_next = S_RD_ISSUE;
               end
            end
         end
         S_WRITE: begin
            if (w_abort) begin
               w_next = S_DONE;
            end else if (w_beat && (r_remain == LenOne)) begin
               w_next = S_DONE;
            end
         end
         S_RD_ISSUE: begin
            if (w_abort) begin
               w_next = S_DONE;
            end else if (w_issue) begin
               w_next = S_RD_CAPTURE;
            end
         end
         S_RD_CAPTURE: begin
            if (w_abort || (r_remain == LenZero)) begin
               w_next = S_DONE;
            end else begin
               w_next = S_RD_ISSUE;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output / strobe decode
   // ---------------------------------------------------------------------
   always_comb begin
      w_cmd_ready = 1'b0;
      w_wr_ready  = 1'b0;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      w_beat      = 1'b0;
      w_issue     = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cmd_ready = 1'b1;
            w_busy      = 1'b0;
         end
         S_WRITE: begin
            // An aborting cycle refuses the beat rather than dropping it.
            w_wr_ready = !w_abort;
            w_beat     = bus.wr_valid && !w_abort;
         end
         S_RD_ISSUE: begin
            // Only fetch when the output register is free or being emptied,
            // so the captured word can never overwrite an unaccepted one.
            w_issue = !w_abort && (!r_rd_valid || bus.rd_ready);
         end
         S_RD_CAPTURE: begin
            w_capture = !w_abort;
         end
         S_DONE: begin
            w_done = 1'b1;
         end
         default: begin
            w_busy = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: address/count, registered RAM write drive, read output
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr        <= '0;
         r_remain      <= '0;
         r_mem_we      <= 1'b0;
         r_mem_address <= '0;
         r_mem_d       <= '0;
         r_rd_data     <= '0;
         r_rd_valid    <= 1'b0;
      end else begin
         r_mem_we <= 1'b0;

         if (w_cmd_ready && bus.cmd_valid) begin
            r_addr   <= bus.cmd_addr;
            r_remain <= bus.cmd_len;
         end

         if (w_beat) begin
            r_mem_we      <= 1'b1;
            r_mem_address <= r_addr;
            r_mem_d       <= bus.wr_data;
            r_addr        <= r_addr + 1'b1;
            r_remain      <= r_remain - 1'b1;
         end

         if (w_issue) begin
            r_mem_address <= r_addr;
            r_addr        <= r_addr + 1'b1;
            r_remain      <= r_remain - 1'b1;
         end

         if (w_capture) begin
            r_rd_data  <= bus.mem_q;
            r_rd_valid <= 1'b1;
         end else if (r_rd_valid && bus.rd_ready) begin
            r_rd_valid <= 1'b0;
         end
      end
   end

   // The read address goes straight to the RAM in the issue cycle so mem_q
   // is ready in the capture cycle; outside that cycle the RAM sees the last
   // registered address.
   assign bus.mem_address = w_issue ? r_addr : r_mem_address;
   assign bus.mem_we      = r_mem_we;
   assign bus.mem_d       = r_mem_d;
   assign bus.rd_data     = r_rd_data;
   assign bus.rd_valid    = r_rd_valid;
   assign bus.cmd_ready   = w_cmd_ready;
   assign bus.wr_ready    = w_wr_ready;
   assign bus.busy        = w_busy;
   assign bus.done        = w_done;

endmodule

// File: tb/tb_ram_burst_master.sv
// ---------------------------------------------------------------------------
// tb_ram_burst_master
//
// Directed bench for ram_burst_master with a behavioural synchronous RAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Cycle c0 is the cycle the command is presented.
// ---------------------------------------------------------------------------
module tb_ram_burst_master;
   localparam int DW = 32;
   localparam int AW = 7;

   localparam logic [DW-1:0] WA = 32'hA000_000A;
   localparam logic [DW-1:0] WB = 32'hB000_000B;
   localparam logic [DW-1:0] WC = 32'hC000_000C;
   localparam logic [DW-1:0] W0 = 32'h1234_0000;
   localparam logic [DW-1:0] W1 = 32'h1234_1111;
   localparam logic [DW-1:0] W2 = 32'h1234_2222;
   localparam logic [DW-1:0] W3 = 32'h1234_3333;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
`ifdef RAM_BURST_MASTER_ABORT_EN
   logic abort = 1'b0;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   ram_burst_master_if #(.Data_width(DW), .Addr_width(AW)) bus ();

   ram_burst_master #(.Data_width(DW), .Addr_width(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef RAM_BURST_MASTER_ABORT_EN
      .abort (abort),
`endif
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // Synchronous RAM model and write counter
   logic [DW-1:0] ram [0:(1<<AW)-1];
   int wr_count = 0;
   always @(posedge clk) begin
      if (bus.mem_we === 1'b1) begin
         ram[bus.mem_address] <= bus.mem_d;
         wr_count <= wr_count + 1;
      end
      bus.mem_q <= ram[bus.mem_address];
   end

   // Per-burst write data and hand-computed expected addresses
   logic [DW-1:0] wd [4];
   logic [AW-1:0] wa [4];

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.wr_data   = '0;
      bus.wr_valid  = 1'b0;
      bus.rd_ready  = 1'b0;
   endtask

   task automatic test_reset;
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done, bus.mem_we} !== 6'b100000) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b expected 100000",
                  {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done, bus.mem_we});
      end
      tests_run++;
      if (bus.rd_data !== '0 || bus.mem_d !== '0) begin
         tests_failed++;
         $display("FAIL reset_data: rd_data %h mem_d %h expected 0", bus.rd_data, bus.mem_d);
      end
      tests_run++;
      if (bus.mem_address !== '0) begin
         tests_failed++;
         $display("FAIL reset_addr: got %h expected 0", bus.mem_address);
      end
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
   endtask

   // Write burst of len words from wd[], expecting RAM addresses wa[].
   task automatic test_write_burst(input string name, input logic [AW-1:0] addr, input int len);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = addr;
      bus.cmd_len   = (AW+1)'(len);
      @(negedge clk);
      tests_run++;
      if (bus.cmd_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_cmd_ready: got %b expected 1", name, bus.cmd_ready);
      end
      next_cycle();
      bus.cmd_valid = 1'b0;
      for (int c = 1; c <= len + 2; c++) begin
         bus.wr_valid = (c <= len);
         bus.wr_data  = (c <= len) ? wd[c-1] : '0;
         @(negedge clk);
         tests_run++;
         if (bus.mem_we !== (c >= 2 && c <= len + 1)) begin
            tests_failed++;
            $display("FAIL %s_mem_we c%0d: got %b", name, c, bus.mem_we);
         end
         if (c >= 2 && c <= len + 1) begin
            tests_run++;
            if (bus.mem_address !== wa[c-2] || bus.mem_d !== wd[c-2]) begin
               tests_failed++;
               $display("FAIL %s_write c%0d: addr %0d data %h expected addr %0d data %h",
                        name, c, bus.mem_address, bus.mem_d, wa[c-2], wd[c-2]);
            end
         end
         tests_run++;
         if ({bus.wr_ready, bus.done, bus.cmd_ready} !== {c <= len, c == len + 1, c == len + 2}) begin
            tests_failed++;
            $display("FAIL %s_ctrl c%0d: wr_ready/done/cmd_ready got %b", name, c,
                     {bus.wr_ready, bus.done, bus.cmd_ready});
         end
         next_cycle();
      end
      bus.wr_valid = 1'b0;
   endtask

   task automatic test_write_basic;
      wd[0] = WA; wd[1] = WB; wd[2] = WC; wd[3] = '0;
      wa[0] = 7'd5; wa[1] = 7'd6; wa[2] = 7'd7; wa[3] = 7'd0;
      test_write_burst("write_basic", 7'd5, 3);
   endtask

   task automatic test_write_wrap;
      wd[0] = W0; wd[1] = W1; wd[2] = W2; wd[3] = W3;
      wa[0] = 7'd126; wa[1] = 7'd127; wa[2] = 7'd0; wa[3] = 7'd1;
      test_write_burst("write_wrap", 7'd126, 4);
   endtask

   task automatic test_read_basic;
      logic [7:0]    ev;
      logic [DW-1:0] ed [3];
      ev = 8'b0101_0100;
      ed[0] = WA; ed[1] = WB; ed[2] = WC;
      bus.rd_ready  = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 7'd5;
      bus.cmd_len   = 8'd3;
      next_cycle();
      bus.cmd_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         tests_run++;
         if (bus.rd_valid !== ev[c-1] || bus.done !== (c == 7) || bus.mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_basic_ctrl c%0d: rd_valid %b done %b mem_we %b expected %b %b 0",
                     c, bus.rd_valid, bus.done, bus.mem_we, ev[c-1], c == 7);
         end
         if (ev[c-1]) begin
            tests_run++;
            if (bus.rd_data !== ed[(c-3)/2]) begin
               tests_failed++;
               $display("FAIL read_basic_data c%0d: got %h expected %h", c, bus.rd_data, ed[(c-3)/2]);
            end
         end
         if (c == 1 || c == 3 || c == 5) begin
            tests_run++;
            if (bus.mem_address !== 7'(5 + (c-1)/2)) begin
               tests_failed++;
               $display("FAIL read_basic_addr c%0d: got %0d expected %0d", c, bus.mem_address, 5 + (c-1)/2);
            end
         end
         next_cycle();
      end
      bus.rd_ready = 1'b0;
   endtask

   task automatic test_read_stall;
      bus.rd_ready  = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 7'd126;
      bus.cmd_len   = 8'd2;
      next_cycle();
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.mem_address !== 7'd126) begin
         tests_failed++;
         $display("FAIL stall_first_addr: got %0d expected 126", bus.mem_address);
      end
      next_cycle();
      next_cycle();
      for (int c = 3; c <= 7; c++) begin
         @(negedge clk);
         tests_run++;
         if (bus.rd_valid !== 1'b1 || bus.rd_data !== W0 || bus.mem_address !== 7'd126 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_hold c%0d: valid %b data %h addr %0d busy %b expected 1 %h 126 1",
                     c, bus.rd_valid, bus.rd_data, bus.mem_address, bus.busy, W0);
         end
         next_cycle();
      end
      bus.rd_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== W0 || bus.mem_address !== 7'd127) begin
         tests_failed++;
         $display("FAIL stall_release: valid %b data %h addr %0d expected 1 %h 127",
                  bus.rd_valid, bus.rd_data, bus.mem_address, W0);
      end
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (bus.rd_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL stall_accepted: rd_valid got %b expected 0", bus.rd_valid);
      end
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== W1 || bus.done !== 1'b1) begin
         tests_failed++;
         $display("FAIL stall_second: valid %b data %h done %b expected 1 %h 1",
                  bus.rd_valid, bus.rd_data, bus.done, W1);
      end
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (bus.rd_valid !== 1'b0 || bus.done !== 1'b0) begin
         tests_failed++;
         $display("FAIL stall_end: valid %b done %b expected 0 0", bus.rd_valid, bus.done);
      end
      bus.rd_ready = 1'b0;
      next_cycle();
   endtask

   // Last word stays pending into IDLE; a following read waits for it.
   task automatic test_pending;
      bus.rd_ready  = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 7'd1;
      bus.cmd_len   = 8'd1;
      next_cycle();
      bus.cmd_valid = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== W3 || bus.done !== 1'b1) begin
         tests_failed++;
         $display("FAIL pending_done: valid %b data %h done %b expected 1 %h 1",
                  bus.rd_valid, bus.rd_data, bus.done, W3);
      end
      next_cycle();
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = 7'd0;
      bus.cmd_len   = 8'd1;
      @(negedge clk);
      tests_run++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== W3 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL pending_idle: valid %b data %h cmd_ready %b busy %b expected 1 %h 1 0",
                  bus.rd_valid, bus.rd_data, bus.cmd_ready, bus.busy, W3);
      end
      next_cycle();
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== W3 || bus.mem_address !== 7'd1) begin
         tests_failed++;
         $display("FAIL pending_no_issue: valid %b data %h addr %0d expected 1 %h 1",
                  bus.rd_valid, bus.rd_data, bus.mem_address, W3);
      end
      next_cycle();
      bus.rd_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.mem_address !== 7'd0) begin
         tests_failed++;
         $display("FAIL pending_issue: addr got %0d expected 0", bus.mem_address);
      end
      next_cycle();
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== W2 || bus.done !== 1'b1) begin
         tests_failed++;
         $display("FAIL pending_second: valid %b data %h done %b expected 1 %h 1",
                  bus.rd_valid, bus.rd_data, bus.done, W2);
      end
      next_cycle();
      bus.rd_ready = 1'b0;
      next_cycle();
   endtask

   task automatic test_zero_len;
      int done_cnt;
      int we_cnt;
      done_cnt = 0;
      we_cnt   = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 7'd40;
      bus.cmd_len   = 8'd0;
      next_cycle();
      bus.cmd_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1) done_cnt++;
         if (bus.mem_we !== 1'b0) we_cnt++;
         tests_run++;
         if ({bus.busy, bus.cmd_ready} !== {c == 1, c != 1}) begin
            tests_failed++;
            $display("FAIL zero_len_state c%0d: busy/cmd_ready got %b", c, {bus.busy, bus.cmd_ready});
         end
         next_cycle();
      end
      tests_run++;
      if (done_cnt !== 1 || we_cnt !== 0) begin
         tests_failed++;
         $display("FAIL zero_len_pulse: done pulses %0d mem_we cycles %0d expected 1 0", done_cnt, we_cnt);
      end
   endtask

   task automatic test_reset_mid;
      int snap;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 7'd10;
      bus.cmd_len   = 8'd4;
      next_cycle();
      bus.cmd_valid = 1'b0;
      bus.wr_valid  = 1'b1;
      bus.wr_data   = 32'hDEAD_0001;
      next_cycle();
      bus.wr_data   = 32'hDEAD_0002;
      rst_n         = 1'b0;
      @(negedge clk);
      snap = wr_count;
      tests_run++;
      if ({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done, bus.mem_we} !== 6'b100000
          || bus.mem_address !== '0 || bus.mem_d !== '0) begin
         tests_failed++;
         $display("FAIL reset_mid_outputs: flags %b addr %0d mem_d %h expected 100000 0 0",
                  {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done, bus.mem_we},
                  bus.mem_address, bus.mem_d);
      end
      next_cycle();
      next_cycle();
      rst_n        = 1'b1;
      bus.wr_valid = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (wr_count !== snap || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_after: writes %0d cmd_ready %b busy %b expected %0d 1 0",
                  wr_count, bus.cmd_ready, bus.busy, snap);
      end
      next_cycle();
   endtask

`ifdef RAM_BURST_MASTER_ABORT_EN
   task automatic test_abort;
      int snap;
      snap = wr_count;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 7'd20;
      bus.cmd_len   = 8'd4;
      next_cycle();
      bus.cmd_valid = 1'b0;
      bus.wr_valid  = 1'b1;
      bus.wr_data   = 32'hABCD_0001;
      next_cycle();
      bus.wr_data   = 32'hABCD_0002;
      abort         = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.wr_ready !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_address !== 7'd20) begin
         tests_failed++;
         $display("FAIL abort_cycle: wr_ready %b mem_we %b addr %0d expected 0 1 20",
                  bus.wr_ready, bus.mem_we, bus.mem_address);
      end
      next_cycle();
      abort        = 1'b0;
      bus.wr_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.mem_we !== 1'b0 || bus.done !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_done: mem_we %b done %b expected 0 1", bus.mem_we, bus.done);
      end
      next_cycle();
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (wr_count - snap !== 1 || bus.cmd_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_writes: writes %0d cmd_ready %b expected 1 1", wr_count - snap, bus.cmd_ready);
      end
      next_cycle();
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_basic();
      test_read_basic();
      test_write_wrap();
      test_read_stall();
      test_pending();
      test_zero_len();
      test_reset_mid();
`ifdef RAM_BURST_MASTER_ABORT_EN
      test_abort();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
